// File: rtl/gcd_pkg.sv
// Shared types and constants for the gcd scheduler and its arbiter.
package gcd_pkg;

    localparam int GCD_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } sched_state_e;

endpackage

// File: rtl/gcd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward with wrap-around
// and returns the first requesting index as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int step);
        return IDX_W'((int'(base) + step) % N);
    endfunction

    logic found_s;

    // First set request after the pointer wins; the pointer itself is checked last.
    always_comb begin
        grant_o     = {N{1'b0}};
        grant_idx_o = {IDX_W{1'b0}};
        found_s     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found_s && req_i[wrap_idx(ptr_i, k)]) begin
                grant_o[wrap_idx(ptr_i, k)] = 1'b1;
                grant_idx_o                 = wrap_idx(ptr_i, k);
                found_s                     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one gcd core among N_REQ requesters: round-robin grant, operand latch,
// single start pulse, and a one-cycle done pulse back to the winner.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] a_i,
    input  logic [N_REQ*WIDTH-1:0] b_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic [WIDTH-1:0]       result_o,
    output logic                   busy_o,
    output logic                   gcd_start_o,
    output logic [WIDTH-1:0]       gcd_a_o,
    output logic [WIDTH-1:0]       gcd_b_o,
    input  logic                   gcd_busy_i,
    input  logic                   gcd_valid_i,
    input  logic [WIDTH-1:0]       gcd_result_i
);

    localparam int IDX_W = $clog2(N_REQ);

    sched_state_e     state_r, state_s;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    logic [N_REQ-1:0] gnt_r, gnt_s;
    logic [N_REQ-1:0] done_r, done_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             busy_r, busy_s;
    logic             start_r, start_s;
    logic [WIDTH-1:0] op_a_r, op_a_s;
    logic [WIDTH-1:0] op_b_r, op_b_s;

    logic [N_REQ-1:0] win_gnt_s;
    logic [IDX_W-1:0] win_idx_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req_i       (req_i),
        .ptr_i       (ptr_r),
        .grant_o     (win_gnt_s),
        .grant_idx_o (win_idx_s)
    );

    // AND-OR mux of the winner's operand slices.
    always_comb begin
        sel_a_s = {WIDTH{1'b0}};
        sel_b_s = {WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s = sel_a_s | (a_i[i*WIDTH +: WIDTH] & {WIDTH{win_gnt_s[i]}});
            sel_b_s = sel_b_s | (b_i[i*WIDTH +: WIDTH] & {WIDTH{win_gnt_s[i]}});
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        gnt_s    = gnt_r;
        done_s   = {N_REQ{1'b0}};
        result_s = result_r;
        op_a_s   = op_a_r;
        op_b_s   = op_b_r;
        case (state_r)
            S_IDLE: begin
                if ((req_i != {N_REQ{1'b0}}) && !gcd_busy_i) begin
                    gnt_s   = win_gnt_s;
                    ptr_s   = win_idx_s;
                    op_a_s  = sel_a_s;
                    op_b_s  = sel_b_s;
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                // Operands stay put here: the core samples them the cycle after start.
                if (gcd_valid_i) begin
                    result_s = gcd_result_i;
                    done_s   = gnt_r;
                    state_s  = S_DRAIN;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                gnt_s   = {N_REQ{1'b0}};
                state_s = S_IDLE;
            end
            default: begin
                gnt_s   = {N_REQ{1'b0}};
                state_s = S_IDLE;
            end
        endcase
        busy_s  = (state_s != S_IDLE);
        start_s = (state_s == S_START);
    end

    // State and output registers; reset puts ptr at N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= S_IDLE;
            ptr_r    <= IDX_W'(N_REQ - 1);
            gnt_r    <= {N_REQ{1'b0}};
            done_r   <= {N_REQ{1'b0}};
            result_r <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            start_r  <= 1'b0;
            op_a_r   <= {WIDTH{1'b0}};
            op_b_r   <= {WIDTH{1'b0}};
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            gnt_r    <= gnt_s;
            done_r   <= done_s;
            result_r <= result_s;
            busy_r   <= busy_s;
            start_r  <= start_s;
            op_a_r   <= op_a_s;
            op_b_r   <= op_b_s;
        end
    end

    assign gnt_o       = gnt_r;
    assign done_o      = done_r;
    assign result_o    = result_r;
    assign busy_o      = busy_r;
    assign gcd_start_o = start_r;
    assign gcd_a_o     = op_a_r;
    assign gcd_b_o     = op_b_r;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Scoreboard bench for gcd_scheduler with a behavioural gcd core attached.
module tb_gcd_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] a_i;
    logic [N*W-1:0] b_i;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   done_o;
    logic [W-1:0]   result_o;
    logic           busy_o;
    logic           gcd_start_o;
    logic [W-1:0]   gcd_a_o;
    logic [W-1:0]   gcd_b_o;
    logic           gcd_busy_i;
    logic           gcd_valid_i;
    logic [W-1:0]   gcd_result_i;

    gcd_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .busy_o       (busy_o),
        .gcd_start_o  (gcd_start_o),
        .gcd_a_o      (gcd_a_o),
        .gcd_b_o      (gcd_b_o),
        .gcd_busy_i   (gcd_busy_i),
        .gcd_valid_i  (gcd_valid_i),
        .gcd_result_i (gcd_result_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural core: load operands the cycle after start, compute, pulse valid, one post cycle.
    function automatic logic [W-1:0] euclid(input logic [W-1:0] x0, input logic [W-1:0] y0);
        logic [W-1:0] x, y, t;
        x = x0;
        y = y0;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    int           core_ph;
    int           core_cnt;
    logic [W-1:0] core_a, core_b;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_ph      <= 0;
            core_cnt     <= 0;
            core_a       <= '0;
            core_b       <= '0;
            gcd_busy_i   <= 1'b0;
            gcd_valid_i  <= 1'b0;
            gcd_result_i <= '0;
        end else begin
            case (core_ph)
                0: if (gcd_start_o) begin core_ph <= 1; gcd_busy_i <= 1'b1; end
                1: begin core_a <= gcd_a_o; core_b <= gcd_b_o; core_cnt <= 3; core_ph <= 2; end
                2: if (core_cnt == 0) begin
                       gcd_valid_i  <= 1'b1;
                       gcd_result_i <= euclid(core_a, core_b);
                       core_ph      <= 3;
                   end else begin
                       core_cnt <= core_cnt - 1;
                   end
                3: begin gcd_valid_i <= 1'b0; core_ph <= 4; end
                default: begin gcd_busy_i <= 1'b0; core_ph <= 0; end
            endcase
        end
    end

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   start_cnt = 0;
    int   done_cnt = 0;

    logic [W-1:0] op_a[N][4];
    logic [W-1:0] op_b[N][4];
    int           op_n[N];
    int           op_pos[N];
    bit           corrupt_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[i][op_n[i]] = a;
        op_b[i][op_n[i]] = b;
        op_n[i]++;
    endtask

    task automatic expect_txn(input logic [N-1:0] g, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] r);
        exp_t e;
        e.gnt = g; e.a = a; e.b = b; e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            if (op_pos[i] < op_n[i]) begin
                req_i[i]       = 1'b1;
                a_i[i*W +: W]  = op_a[i][op_pos[i]];
                b_i[i*W +: W]  = op_b[i][op_pos[i]];
            end else begin
                req_i[i]       = 1'b0;
                a_i[i*W +: W]  = '0;
                b_i[i*W +: W]  = '0;
            end
        end
        if (corrupt_en && gnt_o[0]) begin
            a_i[W-1:0] = 32'd99;
            b_i[W-1:0] = 32'd77;
        end
    endtask

    task automatic serve(input int budget);
        int  cyc;
        bit  all_done;
        cyc = 0;
        forever begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++)
                if (done_o[i] && op_pos[i] < op_n[i]) op_pos[i]++;
            apply_inputs();
            all_done = 1'b1;
            for (int i = 0; i < N; i++)
                if (op_pos[i] < op_n[i]) all_done = 1'b0;
            if (all_done && exp_q.size() == 0 && !busy_o) break;
            cyc++;
            if (cyc > budget) begin
                checks++;
                errors++;
                $display("FAIL serve_timeout: got %0d pending expected 0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
        check("gnt_clear_after_txns", gnt_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = '0; a_i = '0; b_i = '0;
        for (int i = 0; i < N; i++) begin op_n[i] = 0; op_pos[i] = 0; end
        exp_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    gnt_o, 0);
        check({tag, "_done"},   done_o, 0);
        check({tag, "_result"}, result_o, 0);
        check({tag, "_busy"},   busy_o, 0);
        check({tag, "_start"},  gcd_start_o, 0);
        check({tag, "_gcd_a"},  gcd_a_o, 0);
        check({tag, "_gcd_b"},  gcd_b_o, 0);
    endtask

    // Monitor: compares each start, core-valid and done event against the queue front.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i !== 1'b0) continue;
            if (gcd_start_o) begin
                start_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_start", gcd_start_o, 0);
                end else begin
                    e = exp_q[0];
                    check("start_gnt", gnt_o, e.gnt);
                    check("start_gcd_a", gcd_a_o, e.a);
                    check("start_gcd_b", gcd_b_o, e.b);
                end
            end
            if (gcd_valid_i && exp_q.size() != 0) begin
                e = exp_q[0];
                check("held_gcd_a", gcd_a_o, e.a);
                check("held_gcd_b", gcd_b_o, e.b);
            end
            if (done_o != 0) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_onehot", done_o, e.gnt);
                    check("result", result_o, e.r);
                    check("busy_at_done", busy_o, 1);
                end
            end
        end
    end

    initial begin
        int s0, d0, w;
        rst_i = 1'b1;
        req_i = '0; a_i = '0; b_i = '0;
        for (int i = 0; i < N; i++) begin op_n[i] = 0; op_pos[i] = 0; end
        repeat (2) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;

        // Single requester
        set_op(0, 32'd12, 32'd18);
        expect_txn(4'b0001, 32'd12, 32'd18, 32'd6);
        serve(200);

        // Simultaneous 0,1,2 from a fresh pointer
        do_reset();
        set_op(0, 32'd48, 32'd18); set_op(1, 32'd7, 32'd13); set_op(2, 32'd0, 32'd9);
        expect_txn(4'b0001, 32'd48, 32'd18, 32'd6);
        expect_txn(4'b0010, 32'd7,  32'd13, 32'd1);
        expect_txn(4'b0100, 32'd0,  32'd9,  32'd9);
        serve(300);

        // Requesters 0 and 3 held continuously alternate
        do_reset();
        s0 = start_cnt; d0 = done_cnt;
        set_op(0, 32'd15, 32'd25); set_op(0, 32'd15, 32'd25);
        set_op(3, 32'd27, 32'd36); set_op(3, 32'd27, 32'd36);
        expect_txn(4'b0001, 32'd15, 32'd25, 32'd5);
        expect_txn(4'b1000, 32'd27, 32'd36, 32'd9);
        expect_txn(4'b0001, 32'd15, 32'd25, 32'd5);
        expect_txn(4'b1000, 32'd27, 32'd36, 32'd9);
        serve(400);
        check("fair_starts", start_cnt - s0, 4);
        check("fair_dones",  done_cnt - d0, 4);

        // Zero operands pass through
        do_reset();
        set_op(0, 32'd0, 32'd0); set_op(0, 32'd100, 32'd0);
        expect_txn(4'b0001, 32'd0,   32'd0, 32'd0);
        expect_txn(4'b0001, 32'd100, 32'd0, 32'd100);
        serve(300);

        // Reset while waiting on the core
        do_reset();
        set_op(0, 32'd50, 32'd20);
        expect_txn(4'b0001, 32'd50, 32'd20, 32'd10);
        w = 0;
        while (!gcd_start_o && w < 50) begin
            @(negedge clk_i);
            apply_inputs();
            w++;
        end
        check("midrst_start_seen", gcd_start_o, 1);
        repeat (2) @(negedge clk_i);
        check("midrst_busy_wait", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        op_n[0] = 0; op_pos[0] = 0;
        req_i = '0; a_i = '0; b_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("midrst_no_done", done_o, 0);
        set_op(1, 32'd21, 32'd14);
        expect_txn(4'b0010, 32'd21, 32'd14, 32'd7);
        serve(200);

        // Operands changed after grant are ignored
        do_reset();
        corrupt_en = 1'b1;
        set_op(0, 32'd12, 32'd18);
        expect_txn(4'b0001, 32'd12, 32'd18, 32'd6);
        serve(200);
        corrupt_en = 1'b0;

        repeat (3) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
